red_tree_seq: RTL and testbench



---
 rtl/red_pkg.sv | 30 +++
 rtl/red_lane_adder.sv | 27 ++
 rtl/red_tree_seq.sv | 140 ++++++++++++++
 tb/tb_red_tree_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/red_pkg.sv
// Shared types and size helpers for the multi-cycle lane-reduction adder.
package red_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam int MAX_W = 64;

  function automatic int num_el(input int data_w, input int lane_w);
    return 2 * data_w / lane_w;
  endfunction

  function automatic int num_cyc(input int data_w, input int lane_w, input int lanes_per_cyc);
    return num_el(data_w, lane_w) / lanes_per_cyc;
  endfunction

  // One guard bit above the worst-case lane sum keeps signed sums from wrapping.
  function automatic int acc_w(input int data_w, input int lane_w);
    return lane_w + $clog2(num_el(data_w, lane_w)) + 1;
  endfunction

  function automatic logic [MAX_W-1:0] ext_lane(input logic [MAX_W-1:0] lane,
                                                input int lane_w, input logic sgn);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++)
      r[i] = (i < lane_w) ? lane[i] : (sgn & lane[lane_w-1]);
    return r;
  endfunction

endpackage

// File: rtl/red_lane_adder.sv
// Combinational step of the reduction: adds LANES_PER_CYC extended lanes onto the running sum.
module red_lane_adder
  import red_pkg::*;
#(
  parameter int LANE_W        = 4,
  parameter int LANES_PER_CYC = 2,
  parameter int ACC_W         = 8
) (
  input  logic [LANES_PER_CYC*LANE_W-1:0] lanes,
  input  logic                            lane_signed,
  input  logic [ACC_W-1:0]                acc_in,
  output logic [ACC_W-1:0]                acc_out
);

  logic [MAX_W-1:0] lane_raw;

  // NOTE: combinational blocks use blocking '=' so each loop iteration sees the previous partial sum.
  always_comb begin
    acc_out  = acc_in;
    lane_raw = '0;
    for (int i = 0; i < LANES_PER_CYC; i++) begin
      lane_raw = MAX_W'(lanes[i*LANE_W +: LANE_W]);
      acc_out  = acc_out + ACC_W'(ext_lane(lane_raw, LANE_W, lane_signed));
    end
  end

endmodule

// File: rtl/red_tree_seq.sv
// Multi-cycle signed/unsigned lane-sum reduction with valid/ready on both sides.
// Optional clamping of the final sum and the out_sat flag are built when RED_SAT_EN is defined.
module red_tree_seq
  import red_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int LANE_W        = 4,
  parameter int LANES_PER_CYC = 2,
  parameter int SAT_W         = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_s
`ifdef RED_SAT_EN
  ,
  output logic              out_sat
`endif
);

  localparam int NUM_CYC = num_cyc(DATA_W, LANE_W, LANES_PER_CYC);
  localparam int ACC_W   = acc_w(DATA_W, LANE_W);
  localparam int STEP    = LANES_PER_CYC * LANE_W;
  localparam int CNT_W   = (NUM_CYC > 1) ? $clog2(NUM_CYC) : 1;

  state_t              state, state_nxt;
  logic [2*DATA_W-1:0] sreg;
  logic [ACC_W-1:0]    acc, acc_nxt, res;
  logic [CNT_W-1:0]    cnt;
  logic                sgn;
  logic                last;
  logic                accept;

  assign last   = (cnt == CNT_W'(NUM_CYC - 1));
  assign accept = in_valid && in_ready;

  red_lane_adder #(
    .LANE_W        (LANE_W),
    .LANES_PER_CYC (LANES_PER_CYC),
    .ACC_W         (ACC_W)
  ) u_lane_adder (
    .lanes       (sreg[STEP-1:0]),
    .lane_signed (sgn),
    .acc_in      (acc),
    .acc_out     (acc_nxt)
  );

`ifdef RED_SAT_EN
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 << (SAT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
  localparam logic        [ACC_W-1:0] UMAX = ACC_W'((1 << SAT_W) - 1);
  logic res_sat;

  always_comb begin
    res     = acc_nxt;
    res_sat = 1'b0;
    if (sgn) begin
      if ($signed(acc_nxt) > SMAX) begin
        res     = SMAX;
        res_sat = 1'b1;
      end else if ($signed(acc_nxt) < SMIN) begin
        res     = SMIN;
        res_sat = 1'b1;
      end
    end else if (acc_nxt > UMAX) begin
      res     = UMAX;
      res_sat = 1'b1;
    end
  end
`else
  assign res = acc_nxt;
`endif

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ACCUM;
      end
      ACCUM: if (last) state_nxt = DONE;
      DONE: begin
        // Retiring the result frees the block, so a new operand pair may enter on the same edge.
        in_ready = out_ready;
        if (out_ready) state_nxt = in_valid ? ACCUM : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg      <= '0;
      acc       <= '0;
      cnt       <= '0;
      sgn       <= 1'b0;
      out_s     <= '0;
      out_valid <= 1'b0;
`ifdef RED_SAT_EN
      out_sat   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        sreg <= {in_b, in_a};
        sgn  <= in_signed;
        acc  <= '0;
        cnt  <= '0;
      end else if (state == ACCUM) begin
        acc  <= acc_nxt;
        sreg <= sreg >> STEP;
        cnt  <= cnt + CNT_W'(1);
      end

      if (state == ACCUM && last) begin
        out_valid <= 1'b1;
        out_s     <= {{(DATA_W-ACC_W){sgn & res[ACC_W-1]}}, res};
`ifdef RED_SAT_EN
        out_sat   <= res_sat;
`endif
      end else if (state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_red_tree_seq.sv
// Scoreboard bench for red_tree_seq: default-size instance plus a 32/8/4 instance.
// Expectations follow RED_SAT_EN when that macro is defined for the build.
module tb_red_tree_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        v1, r1, s1, ov1, or1, sat1;
  logic [15:0] a1, b1, os1;
  logic        v2, r2, sg2, ov2, or2, sat2;
  logic [31:0] a2, b2, os2;

  red_tree_seq dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_a(a1), .in_b(b1),
    .in_signed(s1), .out_valid(ov1), .out_ready(or1), .out_s(os1)
`ifdef RED_SAT_EN
    , .out_sat(sat1)
`endif
  );

  red_tree_seq #(.DATA_W(32), .LANE_W(8), .LANES_PER_CYC(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_a(a2), .in_b(b2),
    .in_signed(sg2), .out_valid(ov2), .out_ready(or2), .out_s(os2)
`ifdef RED_SAT_EN
    , .out_sat(sat2)
`endif
  );

`ifndef RED_SAT_EN
  assign sat1 = 1'b0;
  assign sat2 = 1'b0;
`endif

`ifdef RED_SAT_EN
  localparam logic [31:0] E1 = 32'h0000_001F, E2 = 32'h0000_FFE0;
  localparam logic        T1 = 1'b1, T2 = 1'b1;
`else
  localparam logic [31:0] E1 = 32'h0000_0038, E2 = 32'h0000_FFC0;
  localparam logic        T1 = 1'b0, T2 = 1'b0;
`endif

  typedef struct {
    logic [31:0] s;
    logic        sat;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   n_pass = 0;
  int   n_chk  = 0;
  bit   seen1  = 0;
  bit   seen2  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference for the 32-bit / 8-bit-lane instance.
  function automatic void model2(input logic [31:0] a, input logic [31:0] b, input logic sg,
                                 output logic [31:0] s, output logic sat);
    logic [63:0] ops;
    logic [7:0]  l;
    int          sum;
    ops = {b, a};
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      l = ops[i*8 +: 8];
      sum += sg ? int'($signed(l)) : int'(l);
    end
    sat = 1'b0;
`ifdef RED_SAT_EN
    if (sg) begin
      if (sum > 31)       begin sum = 31;  sat = 1'b1; end
      else if (sum < -32) begin sum = -32; sat = 1'b1; end
    end else if (sum > 63) begin
      sum = 63; sat = 1'b1;
    end
`endif
    s = 32'(sum);
  endfunction

  always @(negedge clk) begin
    if (rst) seen1 = 0;
    else if (ov1) begin
      if (q1.size() == 0) check("dut1 spurious out_valid", 32'(q1.size()), 1);
      else begin
        if (!seen1) begin
          seen1 = 1;
          check("dut1 latency", cyc - q1[0].acc, q1[0].lat);
        end
        check("dut1 out_s", {16'h0, os1}, q1[0].s);
        check("dut1 out_sat", {31'h0, sat1}, {31'h0, q1[0].sat});
        if (or1) begin
          void'(q1.pop_front());
          seen1 = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) seen2 = 0;
    else if (ov2) begin
      if (q2.size() == 0) check("dut2 spurious out_valid", 32'(q2.size()), 1);
      else begin
        if (!seen2) begin
          seen2 = 1;
          check("dut2 latency", cyc - q2[0].acc, q2[0].lat);
        end
        check("dut2 out_s", os2, q2[0].s);
        check("dut2 out_sat", {31'h0, sat2}, {31'h0, q2[0].sat});
        if (or2) begin
          void'(q2.pop_front());
          seen2 = 0;
        end
      end
    end
  end

  task automatic send(input bit d, input logic [31:0] a, input logic [31:0] b, input logic sg,
                      input logic [31:0] es, input logic esat, input int lat);
    int   n;
    exp_t e;
    n = 0;
    if (!d) begin v1 = 1'b1; a1 = a[15:0]; b1 = b[15:0]; s1 = sg; end
    else    begin v2 = 1'b1; a2 = a;       b2 = b;       sg2 = sg; end
    #1;
    while ((d ? r2 : r1) !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check(d ? "dut2 in_ready at send" : "dut1 in_ready at send", {31'h0, d ? r2 : r1}, 1);
    e.s = es; e.sat = esat; e.acc = cyc + 1; e.lat = lat;
    if (!d) q1.push_back(e);
    else    q2.push_back(e);
    tick();
    if (!d) v1 = 1'b0;
    else    v2 = 1'b0;
  endtask

  task automatic wait_done(input bit d);
    int n;
    n = 0;
    while ((d ? q2.size() : q1.size()) > 0 && n < 200) begin
      tick();
      n++;
    end
    check(d ? "dut2 drain" : "dut1 drain", 32'(d ? q2.size() : q1.size()), 0);
  endtask

  initial begin
    logic [31:0] ra, rb, es;
    logic        rs, esat;
    int          n;

    rst = 1'b1;
    v1 = 0; a1 = '0; b1 = '0; s1 = 0; or1 = 1;
    v2 = 0; a2 = '0; b2 = '0; sg2 = 0; or2 = 1;
    tick();
    tick();
    check("reset dut1 in_ready",  {31'h0, r1}, 1);
    check("reset dut1 out_valid", {31'h0, ov1}, 0);
    check("reset dut1 out_s",     {16'h0, os1}, 0);
    check("reset dut2 in_ready",  {31'h0, r2}, 1);
    check("reset dut2 out_valid", {31'h0, ov2}, 0);
    check("reset dut2 out_s",     os2, 0);
    rst = 1'b0;
    tick();

    send(0, 32'h7777, 32'h7777, 1'b1, E1, T1, 4);
    wait_done(0);
    send(0, 32'h8888, 32'h8888, 1'b1, E2, T2, 4);
    wait_done(0);
    send(0, 32'hFFFF, 32'h0001, 1'b0, 32'h003D, 1'b0, 4);
    wait_done(0);

    // Backpressure: result must hold while the consumer stalls.
    or1 = 1'b0;
    send(0, 32'h1111, 32'h2222, 1'b1, 32'h000C, 1'b0, 4);
    n = 0;
    while (!ov1 && n < 20) begin
      tick();
      n++;
    end
    check("bp out_valid", {31'h0, ov1}, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp in_ready", {31'h0, r1}, 0);
    end
    or1 = 1'b1;
    send(0, 32'hFFFF, 32'hFFFF, 1'b1, 32'hFFF8, 1'b0, 4);
    wait_done(0);

    // Reset mid-accumulation discards the partial result.
    send(0, 32'h7777, 32'h7777, 1'b1, E1, T1, 4);
    tick();
    rst = 1'b1;
    #1;
    check("abort out_valid", {31'h0, ov1}, 0);
    check("abort out_s",     {16'h0, os1}, 0);
    check("abort in_ready",  {31'h0, r1}, 1);
    q1.delete();
    tick();
    rst = 1'b0;
    tick();
    send(0, 32'h1234, 32'h0000, 1'b1, 32'h000A, 1'b0, 4);
    wait_done(0);

    // Wider instance against the reference model.
    send(1, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 1'b1, 32'h0000_0000, 1'b0, 2);
    q2[$].s = 32'h0;
    model2(32'h7F7F_7F7F, 32'h7F7F_7F7F, 1'b1, es, esat);
    q2[$].s = es;
    q2[$].sat = esat;
    wait_done(1);
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      model2(ra, rb, rs, es, esat);
      send(1, ra, rb, rs, es, esat, 2);
      wait_done(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
